// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: green/yellow/all-red sequencer with demand skipping and flashing-yellow override
module traffic_light_ctrl #(
    parameter int NUM_WAYS = 4,
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int CNT_W    = 8,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  demand_mode,
    input  logic                  flash_mode,
    input  logic [NUM_WAYS-1:0]   req,
    output logic [3*NUM_WAYS-1:0] tl_export,
    output logic [CNT_W-1:0]      remain,
    output logic [WAY_W-1:0]      way,
    output logic                  tick_led
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] ST_ALL_RED = 2'd0;
    localparam logic [1:0] ST_GREEN   = 2'd1;
    localparam logic [1:0] ST_YELLOW  = 2'd2;
    localparam logic [1:0] ST_FLASH   = 2'd3;

    logic [1:0]          state;
    logic [PW-1:0]       presc;
    logic [NUM_WAYS-1:0] req_lat;
    logic [NUM_WAYS-1:0] lat_set;
    logic [NUM_WAYS-1:0] serve_mask;
    logic [WAY_W-1:0]    nw;
    logic                flash_ph;
    logic                tick;
    logic                others;

    function automatic logic [WAY_W-1:0] wrap(input int v);
        return WAY_W'(v % NUM_WAYS);
    endfunction

    assign tick       = presc == PW'(TICK_DIV - 1);
    assign serve_mask = (state == ST_GREEN || state == ST_YELLOW) ? NUM_WAYS'(1) << way : '0;
    assign lat_set    = req_lat | (req & ~serve_mask);
    assign others     = |(req_lat & ~(NUM_WAYS'(1) << way));

    // next way: nearest latched request after the current way (descending scan keeps the closest), else plain rotation
    always_comb begin
        nw = wrap(int'(way) + 1);
        for (int i = NUM_WAYS; i >= 1; i--)
            if (demand_mode && req_lat[wrap(int'(way) + i)]) nw = wrap(int'(way) + i);
    end

    // light decode from registered state only
    always_comb begin
        tl_export = '0;
        for (int k = 0; k < NUM_WAYS; k++)
            tl_export[3*k +: 3] = state == ST_FLASH ? (flash_ph ? 3'b010 : 3'b000) :
                                  (state == ST_GREEN  && way == WAY_W'(k)) ? 3'b001 :
                                  (state == ST_YELLOW && way == WAY_W'(k)) ? 3'b010 : 3'b100;
    end

    // phase sequencing, prescaler, request latches and heartbeat
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= ST_ALL_RED;
            way      <= WAY_W'(NUM_WAYS - 1);
            remain   <= CNT_W'(ALLRED_T);
            presc    <= '0;
            req_lat  <= '0;
            tick_led <= 1'b0;
            flash_ph <= 1'b0;
        end else begin
            if (tick) tick_led <= ~tick_led;
            presc   <= tick ? '0 : presc + 1'b1;
            req_lat <= lat_set;
            if (flash_mode) begin
                if (state != ST_FLASH) begin
                    state    <= ST_FLASH;
                    presc    <= '0;
                    flash_ph <= 1'b1;
                end else if (tick) begin
                    flash_ph <= ~flash_ph;
                end
            end else if (state == ST_FLASH) begin
                state  <= ST_ALL_RED;
                remain <= CNT_W'(ALLRED_T);
                presc  <= '0;
            end else if (tick) begin
                if (remain != CNT_W'(1)) begin
                    remain <= remain - 1'b1;
                end else if (state == ST_ALL_RED) begin
                    state   <= ST_GREEN;
                    way     <= nw;
                    remain  <= CNT_W'(GREEN_T);
                    req_lat <= lat_set & ~(NUM_WAYS'(1) << nw);
                end else if (state == ST_GREEN) begin
                    if (demand_mode && !others) begin
                        remain <= CNT_W'(GREEN_T);
                    end else begin
                        state  <= ST_YELLOW;
                        remain <= CNT_W'(YELLOW_T);
                    end
                end else begin
                    state  <= ST_ALL_RED;
                    remain <= CNT_W'(ALLRED_T);
                end
            end
        end
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed scenarios plus random traffic checked against an elapsed-time model
module tb_traffic_light_ctrl;
    localparam int NW = 4;
    localparam int TD = 4;
    localparam int GT = 3;
    localparam int YT = 2;
    localparam int RT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          demand_mode = 1'b0;
    logic          flash_mode = 1'b0;
    logic [NW-1:0] req = '0;
    logic [11:0]   tl_export;
    logic [7:0]    remain;
    logic [1:0]    way;
    logic          tick_led;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;

    traffic_light_ctrl #(
        .NUM_WAYS(NW), .TICK_DIV(TD), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(RT), .CNT_W(8)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .demand_mode(demand_mode), .flash_mode(flash_mode),
        .req(req), .tl_export(tl_export), .remain(remain), .way(way), .tick_led(tick_led)
    );

    always #5 clk = ~clk;

    typedef enum int {RED_CLR, GO, CAUTION, BLINK} ph_t;
    ph_t m_ph;
    int  m_el;
    int  m_T;
    int  m_frozen;
    int  m_way;
    bit  m_pend[NW];
    bit  m_tled;

    function automatic int m_remain();
        return m_ph == BLINK ? m_frozen : m_T - m_el / TD;
    endfunction

    function automatic logic [11:0] m_lights();
        logic [11:0] v = '0;
        for (int k = 0; k < NW; k++) begin
            logic [2:0] s = 3'b100;
            if (m_ph == BLINK) s = ((m_el / TD) % 2 == 0) ? 3'b010 : 3'b000;
            else if (k == m_way && m_ph == GO) s = 3'b001;
            else if (k == m_way && m_ph == CAUTION) s = 3'b010;
            v[3*k +: 3] = s;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_ph = RED_CLR; m_T = RT; m_el = 0; m_way = NW - 1; m_tled = 0; m_frozen = 0;
        for (int k = 0; k < NW; k++) m_pend[k] = 0;
    endtask

    task automatic model_step();
        bit tick;
        bit nxt[NW];
        bit others;
        int nw;
        tick = (m_el % TD) == TD - 1;
        for (int k = 0; k < NW; k++)
            nxt[k] = m_pend[k] | (req[k] && !((m_ph == GO || m_ph == CAUTION) && k == m_way));
        if (tick) m_tled = !m_tled;
        if (flash_mode) begin
            if (m_ph != BLINK) begin m_frozen = m_remain(); m_ph = BLINK; m_el = 0; end
            else m_el++;
        end else if (m_ph == BLINK) begin
            m_ph = RED_CLR; m_T = RT; m_el = 0;
        end else if (m_el + 1 == m_T * TD) begin
            m_el = 0;
            if (m_ph == RED_CLR) begin
                nw = (m_way + 1) % NW;
                if (demand_mode)
                    for (int i = NW; i >= 1; i--) if (m_pend[(m_way + i) % NW]) nw = (m_way + i) % NW;
                m_way = nw; nxt[nw] = 0; m_ph = GO; m_T = GT;
            end else if (m_ph == GO) begin
                others = 0;
                for (int k = 0; k < NW; k++) if (k != m_way && m_pend[k]) others = 1;
                if (!(demand_mode && !others)) begin m_ph = CAUTION; m_T = YT; end
            end else begin
                m_ph = RED_CLR; m_T = RT;
            end
        end else begin
            m_el++;
        end
        m_pend = nxt;
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) model_reset();
        else model_step();

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            chk("cyc tl_export", tl_export, m_lights());
            chk("cyc way", way, m_way);
            chk("cyc remain", remain, m_remain());
            chk("cyc tick_led", tick_led, m_tled);
        end

    task automatic pin(input string name, input logic [11:0] mask, input logic [11:0] tl, input int w, input int r);
        chk({name, " dut tl"}, tl_export & mask, tl);
        chk({name, " dut way"}, way, w);
        chk({name, " dut remain"}, remain, r);
        chk({name, " model tl"}, m_lights() & mask, tl);
        chk({name, " model way"}, m_way, w);
        chk({name, " model remain"}, m_remain(), r);
    endtask

    task automatic adv_to(input int n);
        while (cyc < n) begin @(negedge clk); cyc++; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = -1;
    endtask

    initial begin
        // fixed cycle
        do_reset();
        adv_to(0);   pin("reset", 12'hFFF, 12'h924, 3, 1);
        adv_to(4);   pin("w0 green start", 12'h007, 12'h001, 0, 3);
        adv_to(15);  pin("w0 green end", 12'h007, 12'h001, 0, 1);
        adv_to(16);  pin("w0 yellow start", 12'h007, 12'h002, 0, 2);
        adv_to(23);  pin("w0 yellow end", 12'h007, 12'h002, 0, 1);
        adv_to(24);  pin("allred start", 12'hFFF, 12'h924, 0, 1);
        adv_to(27);  pin("allred end", 12'hFFF, 12'h924, 0, 1);
        adv_to(28);  pin("w1 green", 12'h038, 12'h008, 1, 3);
        adv_to(100); pin("wrap w0 green", 12'h007, 12'h001, 0, 3);
        // demand skip, rest in green, flash override
        demand_mode = 1'b1;
        do_reset();
        adv_to(5);   req = 4'b0100;
        adv_to(6);   req = '0;
        adv_to(16);  pin("demand yellow", 12'h007, 12'h002, 0, 2);
        adv_to(28);  pin("skip to w2", 12'h1C0, 12'h040, 2, 3);
        adv_to(36);  pin("rest rem1", 12'h1C0, 12'h040, 2, 1);
        adv_to(40);  pin("rest reload", 12'h1C0, 12'h040, 2, 3);
        adv_to(42);  flash_mode = 1'b1;
        adv_to(43);  pin("flash on", 12'hFFF, 12'h492, 2, 3);
        adv_to(47);  pin("flash dark", 12'hFFF, 12'h000, 2, 3);
        adv_to(51);  pin("flash lit", 12'hFFF, 12'h492, 2, 3);
        adv_to(52);  flash_mode = 1'b0;
        adv_to(53);  pin("flash exit", 12'hFFF, 12'h924, 2, 1);
        adv_to(57);  pin("after flash w3", 12'hE00, 12'h200, 3, 3);
        // simultaneous set/clear on green entry, then async reset mid-yellow
        do_reset();
        adv_to(5);   req = 4'b0010;
        adv_to(6);   req = '0;
        adv_to(27);  req = 4'b0010;
        adv_to(28);  pin("w1 entry", 12'h038, 12'h008, 1, 3);
        adv_to(29);  req = '0;
        adv_to(40);  pin("w1 rests", 12'h038, 12'h008, 1, 3);
        adv_to(41);  demand_mode = 1'b0;
        adv_to(50);  pin("w1 rem1", 12'h038, 12'h008, 1, 1);
        adv_to(52);  pin("w1 yellow", 12'h038, 12'h010, 1, 2);
        adv_to(54);
        #3 rst_n = 1'b0;
        #1;
        pin("async reset", 12'hFFF, 12'h924, 3, 1);
        chk("async reset tick_led", tick_led, 1'b0);
        // random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            adv_to(i);
            req = ($urandom % 4 == 0) ? NW'(1) << $urandom_range(0, NW - 1) : '0;
            if ($urandom % 150 == 0) demand_mode = ~demand_mode;
            if ($urandom % (flash_mode ? 40 : 400) == 0) flash_mode = ~flash_mode;
        end
        adv_to(4002);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised hardware traffic-light sequencer for NUM_WAYS approaches, replacing per-light software bit-banging of the 3-bit light exports. It runs a fixed green/yellow/all-red cycle with tick-based phase timers, an optional demand (sensor-request) mode that skips unrequested ways, and a flashing-yellow override. It exposes a countdown and active-way index for the seven-segment and LED display logic.

## Interface

- NUM_WAYS, 4: number of approaches, legal range 2..8.
- TICK_DIV, 50000000: clock cycles per timer tick; 1 s at 50 MHz.
- GREEN_T, 20: green duration in ticks, at least 1.
- YELLOW_T, 3: yellow duration in ticks, at least 1.
- ALLRED_T, 2: all-red clearance in ticks, at least 1.
- CNT_W, 8: countdown width. Must hold max(GREEN_T, YELLOW_T, ALLRED_T).
- WAY_W, $clog2(NUM_WAYS): way index width. Derived; not overridden.

- clk_clk, in, 1: single system clock.
- reset_reset_n, in, 1: asynchronous, active-low reset.
- demand_mode, in, 1: 1 enables request-driven way selection.
- flash_mode, in, 1: 1 forces the flashing-yellow override.
- req, in, NUM_WAYS: per-way vehicle request. Synchronous to clk_clk; a 1-cycle pulse suffices.
- tl_export, out, 3*NUM_WAYS: way k occupies bits [3k+2:3k] as {red, yellow, green}.
- remain, out, CNT_W: ticks remaining in the current phase.
- way, out, WAY_W: index of the way currently served.
- tick_led, out, 1: toggles on every tick; heartbeat.

## Operation

- States: ALL_RED, GREEN, YELLOW, FLASH.
- Reset values:
  - state = ALL_RED, way = NUM_WAYS-1, remain = ALLRED_T.
  - Prescaler = 0, req latches = 0, tick_led = 0, flash phase = 0.
  - tl_export = 3'b100 for every way.
- Light decode:
  - GREEN: the served way shows 001; all other ways show 100.
  - YELLOW: the served way shows 010; all other ways show 100.
  - ALL_RED: every way shows 100.
  - FLASH: every way shows 010 while flash phase = 1, and 000 while it is 0.
- Outputs are decoded from registered state only. There is no combinational path from any input to any output.
- Prescaler:
  - Counts 0..TICK_DIV-1; the tick is the cycle with count = TICK_DIV-1.
  - Cleared on every state entry and on every GREEN reload.
- Timer: remain is loaded on state entry and decrements on each tick. A tick while remain = 1 ends the phase.
- ALL_RED expiry: choose the next way, enter GREEN with remain = GREEN_T, and clear that way's req latch.
  - demand_mode = 0: next way = (way+1) mod NUM_WAYS.
  - demand_mode = 1: next way is the first latched request, searching cyclically from way+1. If no request is latched, next way = (way+1) mod NUM_WAYS.
- GREEN expiry:
  - demand_mode = 1 and no latched request on any other way: stay in GREEN and reload remain = GREEN_T ("rest in green").
  - Otherwise: go to YELLOW with remain = YELLOW_T.
- YELLOW expiry: go to ALL_RED with remain = ALLRED_T.
- Request latches:
  - req[k] = 1 sets latch k.
  - A request on the currently served way is ignored while that way is in GREEN or YELLOW.
  - A clear on GREEN entry takes priority over a set in the same cycle.
  - Latches keep capturing in every state, including FLASH, whatever demand_mode is.
- FLASH entry and exit:
  - flash_mode = 1 in any state: enter FLASH on the next edge. remain holds its value; flash phase = 1.
  - In FLASH, each tick toggles the flash phase.
  - flash_mode = 0 in FLASH: enter ALL_RED with remain = ALLRED_T. way is unchanged, so service resumes at the next way.
- demand_mode is sampled only at ALL_RED and GREEN expiry. Changing it mid-phase has no immediate effect.
- tick_led toggles on every tick in every state.

## Timing

- Each phase lasts exactly T*TICK_DIV cycles from state entry, because the prescaler is cleared on entry.
- After reset release: way 0 goes green at cycle ALLRED_T*TICK_DIV.
- Reset asserted at any point: all outputs reach their reset values asynchronously, with no wait for a clock edge.
- The effect of a req pulse is visible at the next ALL_RED or GREEN expiry decision; the latch sets on the following edge.
- FLASH entry and exit each take 1 cycle from the flash_mode change.

## Test plan

All scenarios use NUM_WAYS=4, TICK_DIV=4, GREEN_T=3, YELLOW_T=2, ALLRED_T=1.

- Reset and fixed cycle (demand_mode=0):
  - Release reset → tl_export=12'h924, remain=1.
  - Way 0 green (tl_export[2:0]=001) at cycles 4..15.
  - Way 0 yellow (010) at cycles 16..23.
  - All-red at cycles 24..27.
  - Way 1 green at cycle 28; way wraps from 3 back to 0.
- Demand skip:
  - demand_mode=1; pulse req[2] during way-0 green.
  - → After way-0 yellow and all-red, way=2 goes green; way 1 is skipped.
  - → The req[2] latch is clear on that same edge.
- Rest in green: demand_mode=1, no requests → way 0 stays 001 indefinitely, and remain cycles 3,2,1,3 with one tick per step.
- Flash override:
  - Assert flash_mode mid-green → next cycle all ways show 010.
  - → The lights alternate 000/010 every 4 cycles while remain stays frozen.
  - Deassert → 4 cycles all-red, then the next way goes green.
- Asynchronous reset mid-yellow: assert reset_reset_n=0 between clock edges → tl_export=12'h924, way=3, remain=1 immediately.
- Simultaneous events:
  - req[1] pulses on the very cycle way 1 enters GREEN → the latch ends cleared.
  - → With no other requests pending, way 1 then rests in green.
